// File: rtl/mc_datapath.sv
// Multicycle MIPS datapath: PC, IR, MDR, A, B, ALUOut, register file, ALU and
// state register, steered by an external control unit over a unified memory port.
module mc_datapath #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  NS,
    output logic [3:0]  S,
    output logic [5:0]  Op,
    input  logic        PCWr,
    input  logic        PCWrCond,
    input  logic        IorD,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic        IRWr,
    input  logic        MemtoReg,
    input  logic        ALUSrcA,
    input  logic        RegWr,
    input  logic        RegDst,
    input  logic [1:0]  PCSrc,
    input  logic [1:0]  ALUOp,
    input  logic [1:0]  ALUSrcB,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [4:0]  dbg_ra,
    output logic [31:0] dbg_rd
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;

    localparam logic [3:0] S_FETCH = 4'd0;
    localparam logic [3:0] S_LAST  = 4'd9;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    logic [XLEN-1:0] pc, ir, mdr, a, b, alu_out;
    logic [XLEN-1:0] rf [NREG];
    logic [XLEN-1:0] op_a, op_b, alu_res, sext_imm, pc_next, wr_data, rd_a, rd_b;
    logic [4:0]      rs, rt, wr_idx;
    logic [2:0]      alu_ctl;
    logic            zero, pc_en;

    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign sext_imm = {{16{ir[15]}}, ir[15:0]};
    assign Op       = ir[31:26];

    assign mem_addr  = IorD ? alu_out : pc;
    assign mem_wdata = b;
    assign mem_rd    = MemRd & ~rst;
    assign mem_wr    = MemWr & ~rst;

    // Register 0 is hardwired to zero on every read port.
    assign rd_a   = (rs == 5'd0) ? '0 : rf[rs];
    assign rd_b   = (rt == 5'd0) ? '0 : rf[rt];
    assign dbg_rd = (dbg_ra == 5'd0) ? '0 : rf[dbg_ra];

    // Undefined next-state codes fall back to fetch.
    always_ff @(posedge clk) begin
        if (rst)            S <= S_FETCH;
        else if (NS > S_LAST) S <= S_FETCH;
        else                S <= NS;
    end

    always_comb begin
        alu_ctl = ALU_ADD;
        case (ALUOp)
            2'b01: alu_ctl = ALU_SUB;
            2'b10: begin
                case (ir[5:0])
                    6'b100010: alu_ctl = ALU_SUB;
                    6'b100100: alu_ctl = ALU_AND;
                    6'b100101: alu_ctl = ALU_OR;
                    6'b101010: alu_ctl = ALU_SLT;
                    default:   alu_ctl = ALU_ADD;
                endcase
            end
            default: alu_ctl = ALU_ADD;
        endcase
    end

    always_comb begin
        op_a = ALUSrcA ? a : pc;
        op_b = b;
        case (ALUSrcB)
            2'b01:   op_b = 32'd4;
            2'b10:   op_b = sext_imm;
            2'b11:   op_b = {sext_imm[29:0], 2'b00};
            default: op_b = b;
        endcase
    end

    always_comb begin
        alu_res = op_a + op_b;
        case (alu_ctl)
            ALU_SUB: alu_res = op_a - op_b;
            ALU_AND: alu_res = op_a & op_b;
            ALU_OR:  alu_res = op_a | op_b;
            ALU_SLT: alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
            default: alu_res = op_a + op_b;
        endcase
    end

    assign zero = (alu_res == '0);

    always_comb begin
        pc_next = alu_res;
        case (PCSrc)
            2'b01:   pc_next = alu_out;
            2'b10:   pc_next = {pc[31:28], ir[25:0], 2'b00};
            2'b11:   pc_next = pc;
            default: pc_next = alu_res;
        endcase
    end

    assign pc_en   = PCWr | (PCWrCond & zero);
    assign wr_idx  = RegDst ? ir[15:11] : rt;
    assign wr_data = MemtoReg ? mdr : alu_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_PC;
            ir      <= '0;
            mdr     <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
        end else begin
            if (pc_en) pc <= pc_next;
            if (IRWr)  ir <= mem_rdata;
            mdr     <= mem_rdata;
            a       <= rd_a;
            b       <= rd_b;
            alu_out <= alu_res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (RegWr && wr_idx != 5'd0) begin
            rf[wr_idx] <= wr_data;
        end
    end
endmodule

// File: tb/tb_mc_datapath.sv
// Drives mc_datapath with a standard multicycle control unit and random
// instructions, scoring it against an instruction-level MIPS model.
module tb_mc_datapath;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int N_INSTR = 400;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  NS, S;
    logic [5:0]  Op;
    logic        PCWr, PCWrCond, IorD, MemRd, MemWr, IRWr, MemtoReg, ALUSrcA, RegWr, RegDst;
    logic [1:0]  PCSrc, ALUOp, ALUSrcB;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_rd, mem_wr;
    logic [4:0]  dbg_ra;
    logic [31:0] dbg_rd;

    mc_datapath #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .NS(NS), .S(S), .Op(Op),
        .PCWr(PCWr), .PCWrCond(PCWrCond), .IorD(IorD), .MemRd(MemRd), .MemWr(MemWr),
        .IRWr(IRWr), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .RegWr(RegWr), .RegDst(RegDst),
        .PCSrc(PCSrc), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .dbg_ra(dbg_ra), .dbg_rd(dbg_rd)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [4:0] idx; logic [31:0] val; } exp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } st_t;

    exp_t        exp_q[$];
    st_t         st_q[$];
    logic [5:0]  op_q[$];

    int checks = 0;
    int errors = 0;
    int n_issued = 0;
    logic gen_en = 1'b0;
    logic force_bad = 1'b0;
    logic [31:0] cur_instr = 32'h0;

    logic [31:0] env_mem [1024];
    logic [31:0] ref_mem [1024];
    logic [31:0] ref_rf  [32];
    logic [31:0] ref_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Standard multicycle control unit (the DUT's upstream neighbour).
    always_comb begin
        PCWr = 1'b0; PCWrCond = 1'b0; IorD = 1'b0; MemRd = 1'b0; MemWr = 1'b0;
        IRWr = 1'b0; MemtoReg = 1'b0; ALUSrcA = 1'b0; RegWr = 1'b0; RegDst = 1'b0;
        PCSrc = 2'b00; ALUOp = 2'b00; ALUSrcB = 2'b00; NS = 4'd0;
        case (S)
            4'd0: begin MemRd = 1'b1; IRWr = 1'b1; ALUSrcB = 2'b01; PCWr = 1'b1; NS = 4'd1; end
            4'd1: begin
                ALUSrcB = 2'b11;
                case (Op)
                    6'h23, 6'h2B: NS = 4'd2;
                    6'h00:        NS = 4'd6;
                    6'h04:        NS = 4'd8;
                    6'h02:        NS = 4'd9;
                    default:      NS = 4'd0;
                endcase
            end
            4'd2: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; NS = (Op == 6'h23) ? 4'd3 : 4'd5; end
            4'd3: begin MemRd = 1'b1; IorD = 1'b1; NS = 4'd4; end
            4'd4: begin RegWr = 1'b1; MemtoReg = 1'b1; end
            4'd5: begin MemWr = 1'b1; IorD = 1'b1; end
            4'd6: begin ALUSrcA = 1'b1; ALUOp = 2'b10; NS = 4'd7; end
            4'd7: begin RegDst = 1'b1; RegWr = 1'b1; end
            4'd8: begin ALUSrcA = 1'b1; ALUOp = 2'b01; PCWrCond = 1'b1; PCSrc = 2'b01; end
            4'd9: begin PCWr = 1'b1; PCSrc = 2'b10; end
            default: NS = 4'd0;
        endcase
        if (force_bad) NS = 4'hF;
    end

    // Instruction stream on fetch, data memory otherwise.
    always_comb mem_rdata = (S == 4'd0) ? cur_instr : env_mem[mem_addr[11:2]];

    always @(posedge clk) if (mem_wr) env_mem[mem_addr[11:2]] <= mem_wdata;

    // Instruction-level model: execute one random instruction and queue its effects.
    task automatic issue();
        logic [31:0] ins, pc4, npc, a, b, res, sx, addr;
        logic [4:0]  rs, rt, rd, chk;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [25:0] tgt;
        int kind;
        kind = $urandom_range(0, 9);
        rs = 5'($urandom_range(0, 7));
        rt = 5'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 7));
        pc4 = ref_pc + 32'd4;
        npc = pc4;
        chk = rs;
        if (kind <= 3) begin
            case ($urandom_range(0, 5))
                0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24;
                3: fn = 6'h25; 4: fn = 6'h2A; default: fn = 6'($urandom);
            endcase
            ins = {6'h00, rs, rt, rd, 5'd0, fn};
            a = ref_rf[rs]; b = ref_rf[rt];
            case (fn)
                6'h22:   res = a - b;
                6'h24:   res = a & b;
                6'h25:   res = a | b;
                6'h2A:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                default: res = a + b;
            endcase
            if (rd != 5'd0) ref_rf[rd] = res;
            chk = rd;
        end else if (kind <= 6) begin
            imm = 16'($urandom_range(0, 1023)) - 16'd512;
            sx = {{16{imm[15]}}, imm};
            addr = ref_rf[rs] + sx;
            if (kind == 6) begin
                ins = {6'h2B, rs, rt, imm};
                st_q.push_back('{addr: addr, data: ref_rf[rt]});
                ref_mem[addr[11:2]] = ref_rf[rt];
            end else begin
                ins = {6'h23, rs, rt, imm};
                if (rt != 5'd0) ref_rf[rt] = ref_mem[addr[11:2]];
            end
            chk = rt;
        end else if (kind <= 8) begin
            if ($urandom_range(0, 1) == 0) rt = rs;
            imm = 16'($urandom);
            sx = {{16{imm[15]}}, imm};
            ins = {6'h04, rs, rt, imm};
            if (ref_rf[rs] == ref_rf[rt]) npc = pc4 + (sx << 2);
        end else begin
            tgt = 26'($urandom);
            ins = {6'h02, tgt};
            npc = {pc4[31:28], tgt, 2'b00};
        end
        cur_instr = ins;
        ref_pc = npc;
        op_q.push_back(ins[31:26]);
        exp_q.push_back('{pc: npc, idx: chk, val: ref_rf[chk]});
        n_issued++;
    endtask

    initial forever begin
        @(negedge clk); #2;
        if (gen_en && !rst && S == 4'd0) issue();
    end

    // Monitor: architectural state of the previous instruction is visible at each fetch.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst && S == 4'd0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("fetch_pc", mem_addr, e.pc);
            dbg_ra = e.idx;
            #1 check($sformatf("reg%0d", e.idx), dbg_rd, e.val);
        end
    end

    initial forever begin
        logic [5:0] o;
        @(negedge clk);
        if (!rst && S == 4'd1 && op_q.size() > 0) begin
            o = op_q.pop_front();
            check("opcode", 32'(Op), 32'(o));
        end
    end

    initial forever begin
        st_t s;
        @(negedge clk);
        if (mem_wr) begin
            if (st_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_store actual=%h expected=none", mem_addr);
            end else begin
                s = st_q.pop_front();
                check("store_addr", mem_addr, s.addr);
                check("store_data", mem_wdata, s.data);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic done;
        logic [31:0] st_addr, old_word;
        for (int i = 0; i < 1024; i++) begin
            env_mem[i] = (i % 4 == 0) ? $urandom : ($urandom & 32'h0000_0FFC);
            ref_mem[i] = env_mem[i];
        end
        for (int i = 0; i < 32; i++) ref_rf[i] = '0;
        ref_pc = RST_PC;
        dbg_ra = 5'd5;
        rst = 1'b1;

        // Reset state, with fetch strobes gated while reset is high.
        repeat (2) @(negedge clk);
        check("reset_S", 32'(S), 32'd0);
        check("reset_Op", 32'(Op), 32'd0);
        check("reset_mem_addr", mem_addr, RST_PC);
        check("reset_mem_wr", 32'(mem_wr), 32'd0);
        check("reset_mem_rd", 32'(mem_rd), 32'd0);
        check("reset_reg5", dbg_rd, 32'd0);
        #1 rst = 1'b0;
        gen_en = 1'b1;

        for (int c = 0; c < 20 * N_INSTR && n_issued < N_INSTR; c++) @(negedge clk);
        check("issue_complete", 32'(n_issued >= N_INSTR), 32'd1);
        gen_en = 1'b0;

        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk); #3;
            if (exp_q.size() == 0 && S == 4'd0) done = 1'b1;
        end
        check("drain", 32'(done), 32'd1);
        cur_instr = 32'h0000_0020;

        // Undefined next state from decode returns to fetch at PC+4.
        @(negedge clk); #2;
        check("decode_state", 32'(S), 32'd1);
        force_bad = 1'b1;
        @(negedge clk); #1;
        force_bad = 1'b0;
        check("bad_ns_S", 32'(S), 32'd0);
        check("bad_ns_pc", mem_addr, ref_pc + 32'd4);
        cur_instr = 32'hAC22_0008;
        st_addr = ref_rf[1] + 32'd8;
        st_q.push_back('{addr: st_addr, data: ref_rf[2]});

        // Reset landing in the store-write state suppresses the write.
        done = 1'b0;
        for (int c = 0; c < 10 && !done; c++) begin
            @(negedge clk); #2;
            if (S == 4'd5) done = 1'b1;
        end
        check("reach_store_state", 32'(done), 32'd1);
        check("store_strobe", 32'(mem_wr), 32'd1);
        old_word = env_mem[st_addr[11:2]];
        rst = 1'b1;
        #1 check("rst_mem_wr", 32'(mem_wr), 32'd0);
        @(negedge clk); #1;
        rst = 1'b0;
        check("rst_S", 32'(S), 32'd0);
        check("rst_pc", mem_addr, RST_PC);
        check("rst_Op", 32'(Op), 32'd0);
        check("no_store", env_mem[st_addr[11:2]], old_word);
        dbg_ra = 5'd1;
        #1 check("rst_reg1", dbg_rd, 32'd0);
        check("store_q_empty", 32'(st_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
